// File: rtl/cp0_pkg.sv
// Shared CP0 timer/interrupt definitions: register map, TIMCTL layout, handshake FSM states.
package cp0_pkg;

    localparam logic [4:0] COUNT        = 5'd9;
    localparam logic [4:0] COMPARE0     = 5'd11;
    localparam logic [4:0] TIMCTL       = 5'd21;
    localparam logic [4:0] COMPARE_BASE = 5'd21;

    localparam int TIMCTL_DC_BIT = 0;
    localparam int TIMCTL_TI_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } intc_state_e;

    // Compare0 sits at the legacy Count/Compare slot; the extra channels follow TIMCTL.
    function automatic logic [4:0] compare_addr(input int k);
        return (k == 0) ? COMPARE0 : COMPARE_BASE + 5'(k);
    endfunction

    function automatic logic [2:0] highest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cp0_intr_sync.sv
// Multi-flop synchronizer bringing the asynchronous hardware interrupt lines into clk.
module cp0_intr_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/cp0_timer_intc.sv
// CP0 Count/Compare timer with interrupt pending vector and request handshake.
// Define CP0_TIMER_PRESCALE_EN to tick Count every second clock instead of every clock.
module cp0_timer_intc
    import cp0_pkg::*;
#(
    parameter int NUM_CMP     = 2,
    parameter int NUM_HW_INTR = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we_i,
    input  logic [4:0]             waddr_i,
    input  logic [31:0]            wdata_i,
    input  logic [4:0]             raddr_i,
    output logic [31:0]            rdata_o,
    input  logic [NUM_HW_INTR-1:0] intr_i,
    input  logic [1:0]             sw_pend_i,
    input  logic [7:0]             im_i,
    input  logic                   ie_i,
    input  logic                   exl_i,
    output logic [7:0]             ip_o,
    output logic [NUM_CMP-1:0]     timer_intr_o,
    output logic [31:0]            count_o,
    output logic                   intr_req_o,
    output logic [2:0]             intr_id_o,
    input  logic                   intr_ack_i
);

    logic [31:0]              count_q, count_d;
    logic                     dc_q, dc_d;
    logic [NUM_CMP-1:0][31:0] cmp_q, cmp_d;
    logic [NUM_CMP-1:0]       timer_q, timer_d;
    logic [NUM_HW_INTR-1:0]   hw_sync;
    logic [31:0]              timctl_rd;
    logic                     count_wr;
    logic                     tick;
    intc_state_e              state_q, state_d;
    logic [2:0]               id_q, id_d;
    logic [7:0]               masked;
    logic                     can_take;

    assign count_wr = we_i && (waddr_i == COUNT);

`ifdef CP0_TIMER_PRESCALE_EN
    logic phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (count_wr) begin
            phase_d = 1'b0;
        end else if (!dc_q) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase_q <= 1'b0;
        else     phase_q <= phase_d;
    end

    assign tick = phase_q;
`else
    assign tick = 1'b1;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        count_d = count_q;
        dc_d    = dc_q;
        cmp_d   = cmp_q;
        timer_d = timer_q;
        if (count_wr) begin
            count_d = wdata_i;
        end else if (!dc_q && tick) begin
            count_d = count_q + 32'd1;
        end
        if (we_i && (waddr_i == TIMCTL)) begin
            dc_d = wdata_i[TIMCTL_DC_BIT];
        end
        // A Compare write clears its pending bit even when the match fires in the same cycle.
        for (int k = 0; k < NUM_CMP; k++) begin
            if (we_i && (waddr_i == compare_addr(k))) begin
                cmp_d[k]   = wdata_i;
                timer_d[k] = 1'b0;
            end else if ((count_q == cmp_q[k]) && (cmp_q[k] != 32'd0)) begin
                timer_d[k] = 1'b1;
            end
        end
    end

    // NOTE: the Compare array is only a few flops, so it is reset along with the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            dc_q    <= 1'b0;
            cmp_q   <= '0;
            timer_q <= '0;
        end else begin
            count_q <= count_d;
            dc_q    <= dc_d;
            cmp_q   <= cmp_d;
            timer_q <= timer_d;
        end
    end

    cp0_intr_sync #(
        .WIDTH  (NUM_HW_INTR),
        .STAGES (SYNC_STAGES)
    ) u_intr_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (intr_i),
        .sync_o  (hw_sync)
    );

    always_comb begin
        ip_o      = '0;
        ip_o[1:0] = sw_pend_i;
        for (int i = 0; i < NUM_HW_INTR; i++) begin
            ip_o[2+i] = hw_sync[i];
        end
        ip_o[7] = ip_o[7] | (|timer_q);
    end

    always_comb begin
        timctl_rd                = '0;
        timctl_rd[TIMCTL_DC_BIT] = dc_q;
        for (int k = 0; k < NUM_CMP; k++) begin
            timctl_rd[TIMCTL_TI_LSB+k] = timer_q[k];
        end
    end

    always_comb begin
        rdata_o = '0;
        if (raddr_i == COUNT)  rdata_o = count_q;
        if (raddr_i == TIMCTL) rdata_o = timctl_rd;
        for (int k = 0; k < NUM_CMP; k++) begin
            if (raddr_i == compare_addr(k)) rdata_o = cmp_q[k];
        end
    end

    assign masked   = ip_o & im_i;
    assign can_take = (|masked) && ie_i && !exl_i;

    // An ack that coincides with a withdrawal still completes the handshake.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (can_take) begin
                    state_d = ST_REQ;
                    id_d    = highest_set(masked);
                end
            end
            ST_REQ: begin
                if (intr_ack_i)     state_d = ST_WAIT;
                else if (!can_take) state_d = ST_IDLE;
            end
            ST_WAIT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    assign intr_req_o   = (state_q == ST_REQ);
    assign intr_id_o    = id_q;
    assign timer_intr_o = timer_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_cp0_timer_intc.sv
// Directed bench for cp0_timer_intc: timer match/wrap, DC freeze, interrupt handshake, reset.
// Timer cycle counts assume the default build; the prescale step is selected by CP0_TIMER_PRESCALE_EN.
module tb_cp0_timer_intc;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  intr_i;
    logic [1:0]  sw_pend_i;
    logic [7:0]  im_i;
    logic        ie_i;
    logic        exl_i;
    logic [7:0]  ip_o;
    logic [1:0]  timer_intr_o;
    logic [31:0] count_o;
    logic        intr_req_o;
    logic [2:0]  intr_id_o;
    logic        intr_ack_i;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_timer_intc dut (
        .clk          (clk),
        .rst          (rst),
        .we_i         (we_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .raddr_i      (raddr_i),
        .rdata_o      (rdata_o),
        .intr_i       (intr_i),
        .sw_pend_i    (sw_pend_i),
        .im_i         (im_i),
        .ie_i         (ie_i),
        .exl_i        (exl_i),
        .ip_o         (ip_o),
        .timer_intr_o (timer_intr_o),
        .count_o      (count_o),
        .intr_req_o   (intr_req_o),
        .intr_id_o    (intr_id_o),
        .intr_ack_i   (intr_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        we_i    = 1'b1;
        waddr_i = addr;
        wdata_i = data;
        step(1);
        we_i    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
        intr_i = '0; sw_pend_i = '0; im_i = '0; ie_i = 1'b0; exl_i = 1'b0; intr_ack_i = 1'b0;
        step(2);
        check("rst_count", count_o, 32'h0);
        check("rst_timer", 32'(timer_intr_o), 32'h0);
        check("rst_req", 32'(intr_req_o), 32'h0);
        check("rst_id", 32'(intr_id_o), 32'h0);
        check("rst_ip", 32'(ip_o), 32'h0);
        rst = 1'b0;

        // Compare0 = 0x10 from Count reset: match cycle 16, pending visible at cycle 17.
        wr(COMPARE0, 32'h10);
        step(14);
        step(1);
        check("cmp0_at16_count", count_o, 32'h10);
        check("cmp0_at16_timer", 32'(timer_intr_o), 32'h0);
        step(1);
        check("cmp0_at17_timer", 32'(timer_intr_o), 32'h1);
        raddr_i = TIMCTL;
        #1;
        check("timctl_bit8", rdata_o, 32'h100);
        check("ip7_timer", 32'(ip_o), 32'h80);
        wr(COMPARE0, 32'h0);
        check("cmp0_clear", 32'(timer_intr_o), 32'h0);
        raddr_i = COMPARE0;
        #1;
        check("cmp0_read", rdata_o, 32'h0);

        // Count wrap with Compare1 = 1.
        wr(COUNT, 32'hFFFF_FFFE);
        wr(COMPARE_BASE + 5'd1, 32'h1);
        check("wrap_ff", count_o, 32'hFFFF_FFFF);
        step(1);
        check("wrap_zero", count_o, 32'h0);
        check("wrap_zero_timer", 32'(timer_intr_o), 32'h0);
        step(1);
        check("wrap_one", count_o, 32'h1);
        check("wrap_one_timer", 32'(timer_intr_o), 32'h0);
        step(1);
        check("cmp1_set", 32'(timer_intr_o), 32'h2);
        raddr_i = COMPARE_BASE + 5'd1;
        #1;
        check("cmp1_read", rdata_o, 32'h1);
        raddr_i = TIMCTL;
        #1;
        check("timctl_bit9", rdata_o, 32'h200);
        wr(COMPARE_BASE + 5'd1, 32'h0);
        check("cmp1_clear", 32'(timer_intr_o), 32'h0);

        // Count disable freezes Count; writes still load.
        wr(COUNT, 32'h100);
        wr(TIMCTL, 32'h1);
        step(5);
        check("dc_frozen", count_o, 32'h101);
        raddr_i = TIMCTL;
        #1;
        check("timctl_dc", rdata_o, 32'h1);
        wr(COUNT, 32'h1234);
        step(3);
        check("dc_write_load", count_o, 32'h1234);
        wr(TIMCTL, 32'h0);
        step(10);
`ifdef CP0_TIMER_PRESCALE_EN
        check("run_10clk", count_o, 32'h1239);
`else
        check("run_10clk", count_o, 32'h123E);
`endif

        // Hardware line 3 -> IP[5], handshake with ack and re-request.
        im_i = 8'h20; ie_i = 1'b1; intr_i = 6'b001000;
        step(2);
        check("hw_ip5", 32'(ip_o), 32'h20);
        check("hw_req_early", 32'(intr_req_o), 32'h0);
        step(1);
        check("hw_req", 32'(intr_req_o), 32'h1);
        check("hw_id", 32'(intr_id_o), 32'h5);
        intr_ack_i = 1'b1;
        step(1);
        intr_ack_i = 1'b0;
        check("ack_low", 32'(intr_req_o), 32'h0);
        begin
            int waited = 0;
            while (!intr_req_o && waited < 4) begin
                step(1);
                waited++;
            end
        end
        check("rereq", 32'(intr_req_o), 32'h1);
        check("rereq_id", 32'(intr_id_o), 32'h5);
        intr_i = '0;
        step(2);
        check("drop_hold", 32'(intr_req_o), 32'h1);
        step(1);
        check("drop_idle", 32'(intr_req_o), 32'h0);

        // Software IP[0] plus timer pending: highest granted index is 7; EXL withdraws.
        im_i = 8'hFF; ie_i = 1'b0;
        wr(COUNT, 32'h3);
        wr(COMPARE0, 32'h5);
        step(2);
        check("tmr_pending", 32'(timer_intr_o), 32'h1);
        sw_pend_i = 2'b01; ie_i = 1'b1;
        #1;
        check("ip_sw_tmr", 32'(ip_o), 32'h81);
        step(1);
        check("id7_req", 32'(intr_req_o), 32'h1);
        check("id7", 32'(intr_id_o), 32'h7);
        exl_i = 1'b1;
        step(1);
        check("exl_drop", 32'(intr_req_o), 32'h0);
        exl_i = 1'b0;
        step(1);
        check("exl_rereq", 32'(intr_req_o), 32'h1);

        // Asynchronous reset mid-request, ack held high afterwards.
        #3;
        rst = 1'b1; sw_pend_i = 2'b00; raddr_i = COUNT;
        #1;
        check("arst_req", 32'(intr_req_o), 32'h0);
        check("arst_id", 32'(intr_id_o), 32'h0);
        check("arst_timer", 32'(timer_intr_o), 32'h0);
        check("arst_count", count_o, 32'h0);
        check("arst_ip", 32'(ip_o), 32'h0);
        check("arst_rdata", rdata_o, 32'h0);
        intr_ack_i = 1'b1;
        step(2);
        check("arst_ack_hold", 32'(intr_req_o), 32'h0);
        rst = 1'b0;
        step(3);
        check("post_rst_req", 32'(intr_req_o), 32'h0);
        check("post_rst_id", 32'(intr_id_o), 32'h0);
        check("post_rst_count", count_o, 32'h3);
        intr_ack_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
